// File: rtl/iddmm_task_master.sv
// Requester-side agent for the IDDMM task/grant interface: loads one operand pair
// into the multiplier's operand RAM, runs a task, and returns the assembled result.
module iddmm_task_master #(
   parameter int K       = 256,
   parameter int N       = 16,
   parameter int ADDR_W  = $clog2(N),
   parameter int TIMEOUT = 65535
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [N*K-1:0]    req_x,
   input  logic [N*K-1:0]    req_y,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [K-1:0]      wr_data_x,
   output logic [K-1:0]      wr_data_y,
   output logic              task_req,
   input  logic              task_grant,
   input  logic              task_end,
   input  logic [K-1:0]      task_res,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [N*K-1:0]    res_data,
   output logic              res_err,
   output logic              busy
);

   localparam int CNT_W = ADDR_W + 1;
   localparam int WD_W  = $clog2(TIMEOUT + 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(N - 1);
   localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(N);
   localparam logic [WD_W-1:0]   WD_MAX    = WD_W'(TIMEOUT);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_REQ, S_COLLECT, S_DONE} state_t;

   state_t            state, state_n;
   logic [N*K-1:0]    x_lat, y_lat;
   logic [CNT_W-1:0]  wcnt, wcnt_n;
   logic [WD_W-1:0]   wdog, wdog_n;
   logic              granted, granted_n;
   logic              req_ready_n, busy_n, wr_en_n, task_req_n, res_valid_n, res_err_n;
   logic [ADDR_W-1:0] wr_addr_n;
   logic [N*K-1:0]    res_data_n;
   logic              accept;

   assign accept = (state == S_IDLE) && req_valid && req_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         S_IDLE:    if (accept) state_n = S_LOAD;
         S_LOAD:    if (wr_addr == LAST_ADDR) state_n = S_REQ;
         S_REQ:     state_n = S_COLLECT;
         S_COLLECT: begin
            if (task_grant && task_end) state_n = S_DONE;
            else if (!task_grant && !granted && wdog == WD_MAX) state_n = S_DONE;
         end
         S_DONE:    if (res_ready) state_n = S_IDLE;
         default:   state_n = S_IDLE;
      endcase
   end

   // Next values of every registered output and counter
   always_comb begin
      req_ready_n = req_ready;
      busy_n      = busy;
      wr_en_n     = wr_en;
      wr_addr_n   = wr_addr;
      task_req_n  = task_req;
      res_valid_n = res_valid;
      res_err_n   = res_err;
      res_data_n  = res_data;
      wcnt_n      = wcnt;
      wdog_n      = wdog;
      granted_n   = granted;
      case (state)
         S_IDLE: begin
            if (accept) begin
               wr_en_n     = 1'b1;
               wr_addr_n   = '0;
               req_ready_n = 1'b0;
               busy_n      = 1'b1;
               res_data_n  = '0;
            end
         end
         S_LOAD: begin
            if (wr_addr == LAST_ADDR) begin
               wr_en_n    = 1'b0;
               wr_addr_n  = '0;
               task_req_n = 1'b1;
            end else begin
               wr_addr_n = wr_addr + ADDR_W'(1);
            end
         end
         S_REQ: begin
            wcnt_n    = '0;
            wdog_n    = '0;
            granted_n = 1'b0;
         end
         S_COLLECT: begin
            if (task_grant) begin
               granted_n = 1'b1;
               if (wcnt < CNT_FULL) begin
                  res_data_n[int'(wcnt[ADDR_W-1:0]) * K +: K] = task_res;
                  wcnt_n = wcnt + CNT_W'(1);
               end else begin
                  res_err_n = 1'b1;
               end
               if (task_end) begin
                  task_req_n  = 1'b0;
                  res_valid_n = 1'b1;
                  if (wcnt != CNT_LAST) res_err_n = 1'b1;
               end
            end else if (!granted) begin
               if (wdog == WD_MAX) begin
                  task_req_n  = 1'b0;
                  res_err_n   = 1'b1;
                  res_valid_n = 1'b1;
               end else begin
                  wdog_n = wdog + WD_W'(1);
               end
            end
         end
         S_DONE: begin
            if (res_ready) begin
               res_valid_n = 1'b0;
               res_err_n   = 1'b0;
               req_ready_n = 1'b1;
               busy_n      = 1'b0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_ready <= 1'b1;
         busy      <= 1'b0;
         wr_en     <= 1'b0;
         wr_addr   <= '0;
         task_req  <= 1'b0;
         res_valid <= 1'b0;
         res_err   <= 1'b0;
         res_data  <= '0;
         wcnt      <= '0;
         wdog      <= '0;
         granted   <= 1'b0;
      end else begin
         req_ready <= req_ready_n;
         busy      <= busy_n;
         wr_en     <= wr_en_n;
         wr_addr   <= wr_addr_n;
         task_req  <= task_req_n;
         res_valid <= res_valid_n;
         res_err   <= res_err_n;
         res_data  <= res_data_n;
         wcnt      <= wcnt_n;
         wdog      <= wdog_n;
         granted   <= granted_n;
      end
   end

   // Operand words are pure data; word 0 comes straight from the request port
   always_ff @(posedge clk) begin
      if (accept) begin
         x_lat     <= req_x;
         y_lat     <= req_y;
         wr_data_x <= req_x[K-1:0];
         wr_data_y <= req_y[K-1:0];
      end else if (state == S_LOAD && wr_addr != LAST_ADDR) begin
         wr_data_x <= x_lat[(int'(wr_addr) + 1) * K +: K];
         wr_data_y <= y_lat[(int'(wr_addr) + 1) * K +: K];
      end
   end

endmodule

// File: tb/tb_iddmm_task_master.sv
// Scoreboard bench for iddmm_task_master (K=8, N=4, TIMEOUT=20) with a
// behavioural controller model and randomized operands/grants.
module tb_iddmm_task_master;

   localparam int K   = 8;
   localparam int N   = 4;
   localparam int AW  = 2;
   localparam int TMO = 20;

   logic            clk = 1'b0;
   logic            rst;
   logic            req_valid, req_ready;
   logic [N*K-1:0]  req_x, req_y;
   logic            wr_en;
   logic [AW-1:0]   wr_addr;
   logic [K-1:0]    wr_data_x, wr_data_y;
   logic            task_req, task_grant, task_end;
   logic [K-1:0]    task_res;
   logic            res_valid, res_ready, res_err, busy;
   logic [N*K-1:0]  res_data;

   iddmm_task_master #(.K(K), .N(N), .ADDR_W(AW), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x), .req_y(req_y),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data_x(wr_data_x), .wr_data_y(wr_data_y),
      .task_req(task_req), .task_grant(task_grant), .task_end(task_end), .task_res(task_res),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .res_err(res_err), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct { logic [AW-1:0] addr; logic [K-1:0] x; logic [K-1:0] y; } wr_t;
   typedef struct { logic [N*K-1:0] data; logic err; } res_t;

   wr_t        wq[$];
   res_t       rq[$];
   logic [7:0] gw[0:7];
   int         total = 0;
   int         bad = 0;
   int         cyc = 0;
   int         last_wr = -100;
   int         low_cnt = 100;
   logic       prev_treq = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // Monitor: pops expectations whenever the DUT writes or hands off a result
   always @(negedge clk) begin
      wr_t  we;
      res_t re;
      cyc++;
      if (!rst) begin
         if (wr_en) begin
            if (wq.size() == 0) chk("unexpected_write", 1, 0);
            else begin
               we = wq.pop_front();
               chk("wr_addr", wr_addr, we.addr);
               chk("wr_data_x", wr_data_x, we.x);
               chk("wr_data_y", wr_data_y, we.y);
            end
         end
         if (res_valid && res_ready) begin
            if (rq.size() == 0) chk("unexpected_result", 1, 0);
            else begin
               re = rq.pop_front();
               chk("res_data", res_data, re.data);
               chk("res_err", res_err, re.err);
            end
         end
         if (task_req && !prev_treq) begin
            chk("treq_after_last_write", cyc - last_wr, 1);
            chk("treq_low_gap", low_cnt >= N + 1, 1);
         end
         if (wr_en) last_wr = cyc;
         low_cnt   = task_req ? 0 : low_cnt + 1;
         prev_treq = task_req;
      end else begin
         prev_treq = 1'b0;
      end
   end

   task automatic reset_checks();
      chk("rst_req_ready", req_ready, 1);
      chk("rst_wr_en", wr_en, 0);
      chk("rst_wr_addr", wr_addr, 0);
      chk("rst_task_req", task_req, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_err", res_err, 0);
      chk("rst_busy", busy, 0);
      chk("rst_res_data", res_data, 0);
   endtask

   // gap < 0: random 0..2 idle cycles before each grant; otherwise gap idles before grant 1
   task automatic run_task(input logic [31:0] x, input logic [31:0] y, input int ngr,
                           input int gap, input int bp, input bit tmo, input int rst_at);
      res_t e;
      int   t;
      e.data = '0;
      e.err  = tmo || (ngr != N);
      if (!tmo) for (int i = 0; i < ngr && i < N; i++) e.data[i*K +: K] = gw[i];
      t = 0;
      while (!req_ready && t < 50) begin step(); t++; end
      if (!req_ready) begin chk("req_ready_wait", 0, 1); return; end
      for (int i = 0; i < N; i++) begin
         wr_t w;
         w.addr = AW'(i);
         w.x    = x[i*K +: K];
         w.y    = y[i*K +: K];
         wq.push_back(w);
      end
      rq.push_back(e);
      req_valid = 1'b1; req_x = x; req_y = y;
      step();
      req_valid = 1'b0; req_x = $urandom; req_y = $urandom;
      chk("busy_after_accept", busy, 1);
      chk("req_ready_after_accept", req_ready, 0);
      t = 0;
      while (!task_req && t < 30) begin step(); t++; end
      if (!task_req) begin chk("task_req_wait", 0, 1); return; end
      step();
      if (tmo) begin
         t = 0;
         while (!res_valid && t < 40) begin step(); t++; end
         chk("timeout_window", (t >= TMO && t <= TMO + 3), 1);
         chk("timeout_treq_fall", task_req, 0);
      end else begin
         for (int i = 0; i < ngr; i++) begin
            int g;
            g = (gap < 0) ? int'($urandom_range(2, 0)) : ((i == 1) ? gap : 0);
            repeat (g) step();
            chk("treq_held", task_req, 1);
            task_grant = 1'b1; task_res = gw[i]; task_end = (i == ngr - 1);
            step();
            task_grant = 1'b0; task_end = 1'b0; task_res = $urandom;
            if (rst_at == i + 1) begin
               #1 rst = 1'b1;
               #1 reset_checks();
               rq.delete();
               step(); step();
               rst = 1'b0;
               step();
               return;
            end
         end
         chk("treq_fall", task_req, 0);
         chk("res_valid_latency", res_valid, 1);
      end
      for (int c = 0; c < bp; c++) begin
         chk("bp_valid", res_valid, 1);
         chk("bp_data", res_data, e.data);
         chk("bp_err", res_err, e.err);
         chk("bp_req_ready", req_ready, 0);
         req_valid = 1'b1; req_x = $urandom; req_y = $urandom;
         step();
      end
      req_valid = 1'b0;
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
      chk("res_valid_drop", res_valid, 0);
      chk("req_ready_back", req_ready, 1);
      chk("busy_clear", busy, 0);
   endtask

   task automatic fixed_grants();
      gw[0] = 8'hAA; gw[1] = 8'hBB; gw[2] = 8'hCC; gw[3] = 8'hDD;
      gw[4] = 8'hEE; gw[5] = 8'hFF; gw[6] = 8'h11; gw[7] = 8'h22;
   endtask

   task automatic random_grants();
      for (int i = 0; i < 8; i++) gw[i] = 8'($urandom);
   endtask

   initial begin
      int sel;
      rst = 1'b1; req_valid = 1'b0; req_x = '0; req_y = '0;
      task_grant = 1'b0; task_end = 1'b0; task_res = '0; res_ready = 1'b0;
      step(); step();
      reset_checks();
      rst = 1'b0;
      step();

      fixed_grants();
      run_task(32'h04030201, 32'h08070605, 4, 0, 0, 1'b0, -1);
      random_grants();
      run_task($urandom, $urandom, 4, -1, 10, 1'b0, -1);
      fixed_grants();
      run_task($urandom, $urandom, 4, 2, 0, 1'b0, -1);
      run_task($urandom, $urandom, 3, 0, 1, 1'b0, -1);
      run_task($urandom, $urandom, 0, 0, 2, 1'b1, -1);
      random_grants();
      run_task($urandom, $urandom, 4, 0, 0, 1'b0, 2);
      random_grants();
      run_task($urandom, $urandom, 4, -1, 0, 1'b0, -1);
      random_grants();
      run_task($urandom, $urandom, 4, 0, 0, 1'b0, -1);
      random_grants();
      run_task($urandom, $urandom, 4, 0, 0, 1'b0, -1);
      random_grants();
      run_task($urandom, $urandom, 6, -1, 1, 1'b0, -1);
      for (int n = 0; n < 8; n++) begin
         random_grants();
         sel = int'($urandom_range(3, 0));
         run_task($urandom, $urandom, (sel == 0) ? 3 : (sel == 3) ? 5 : 4, -1,
                  int'($urandom_range(3, 0)), 1'b0, -1);
      end

      repeat (5) step();
      chk("write_queue_drained", wq.size(), 0);
      chk("result_queue_drained", rq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
